eth_rx_frame_admit: RTL
=======================

# eth_rx_frame_admit

RX admission controller in the rx_clk domain, inserted between the 1G RGMII MAC receive stream and the RX async FIFO write side. It buffers the 6-byte destination address, decides whether to admit or discard each frame, and truncates oversize frames. Admitted frames are forwarded with the MAC's error flag preserved, and per-frame statistics are kept. The stream has no backpressure on either side, so the block never stalls its input.

## Interface
- MAX_FRAME_LENGTH, 1518: maximum forwarded bytes per frame, FCS included; range 64..65535.
- CNT_WIDTH, 32: width of each statistics counter.

- rx_clk  in  1  receive clock; all logic on its rising edge.
- rx_rst  in  1  reset; asynchronous, active-high.
- s_axis_tdata  in  8  MAC receive byte.
- s_axis_tvalid  in  1  byte valid; may have gaps, because 10/100 modes run at 1/10 or 1/100 duty.
- s_axis_tlast  in  1  last byte of frame.
- s_axis_tuser  in  1  bad-frame flag, meaningful with tlast.
- m_axis_tdata / m_axis_tvalid / m_axis_tlast / m_axis_tuser  out  8/1/1/1  admitted stream to the RX FIFO. Registered; no tready.
- cfg_enable  in  1  admit enable, sampled at frame start.
- cfg_mac_addr  in  48  station address; [47:40] is the first byte on the wire.
- cfg_promisc  in  1  accept any destination address.
- cfg_bcast_en  in  1  accept FF:FF:FF:FF:FF:FF.
- cfg_mcast_en  in  1  accept addresses with byte0[0]=1 that are not broadcast.
- stat_clear  in  1  synchronous clear of all counters.
- stat_rx_frames  out  CNT_WIDTH  count of frames admitted.
- stat_rx_bad  out  CNT_WIDTH  count of admitted frames ending with tuser=1, excluding truncations.
- stat_rx_dropped  out  CNT_WIDTH  count of frames discarded: filtered, disabled, runt, or overlap.
- stat_rx_oversize  out  CNT_WIDTH  count of frames truncated.

## Operation
- Byte buffer:
  - 8 entries of {data, last, user}, with write pointer, read pointer and count.
  - Every input beat in HDR or PASS writes one entry.
  - A `release` flag pops one entry per cycle into the output register while the buffer is non-empty.
  - Popping an entry with last=1 clears `release`.
- States: IDLE, HDR, PASS, DISCARD.
- IDLE:
  - On a valid beat, latch `en_q = cfg_enable`, write byte 0, clear the byte counter to 1, and go to HDR.
  - If the buffer is still non-empty (previous frame draining), go to DISCARD instead and increment stat_rx_dropped.
- HDR:
  - Each beat compares against its cfg_mac_addr byte and updates match, all-FF and multicast flags.
  - A beat with tlast before 6 bytes (runt): flush the buffer, increment dropped, go to IDLE.
  - On the 6th beat (no tlast), compute `accept = en_q & (cfg_promisc | da_match | (cfg_bcast_en & bcast) | (cfg_mcast_en & mcast & ~bcast))`.
    - accept: set `release` and go to PASS.
    - reject: flush the buffer, increment dropped, go to DISCARD.
- PASS:
  - Beats are written with their tlast and tuser.
  - Input tlast: increment frames, and also bad if tuser=1; go to IDLE.
  - Beat number MAX_FRAME_LENGTH without tlast: write it with last=1, user=1; increment frames and oversize; go to DISCARD.
- DISCARD: ignore beats; on tlast go to IDLE.
- Byte counter: 16 bits, counts input beats of the current frame.
- Counters:
  - Saturate at all-ones.
  - stat_clear has priority over same-cycle increments.
  - Multiple counters may increment in the same cycle.
- Config inputs other than cfg_enable are sampled on the 6th beat, so mid-frame changes apply to that frame only if they occur before the decision.

## Timing
- Reset values: all outputs 0, state IDLE, buffer empty, release=0.
- Latency:
  - Input byte 5 sampled at cycle N; byte 0 appears on m_axis at cycle N+2.
  - Subsequent bytes follow one per cycle while buffered; occupancy never exceeds 7.
- m_axis_tvalid is high for exactly one cycle per forwarded byte.
- Gaps follow the input once the buffer has drained.
- Inter-frame gap:
  - A new frame may start once the previous frame's buffer is empty.
  - At 1G the minimum gap is 20 cycles; worst-case drain is 7 cycles.
- Simultaneous events: the tlast beat and the buffer's final pop in the same cycle are legal.
- Reset mid-frame:
  - Output deasserts asynchronously.
  - The partially forwarded frame is not terminated; the RX FIFO is reset together with this block by rx_rst.

## Test plan
- Unicast frame of 64 bytes, DA = cfg_mac_addr = 02:00:00:00:00:01 -> 64 bytes out unchanged; first output byte 2 cycles after input byte 5; tlast on byte 64; frames=1.
- Same frame with DA 02:00:00:00:00:02 and promisc=0 -> no m_axis_tvalid; dropped=1. Repeat with promisc=1 -> forwarded, frames=1.
- Broadcast frame with bcast_en=0, then with bcast_en=1; multicast 01:00:5E:00:00:01 with mcast_en=1 -> dropped=1, frames=2.
- 2000-byte frame, MAX_FRAME_LENGTH=1518 -> exactly 1518 bytes out, byte 1518 has tlast=1 and tuser=1; oversize=1; the next frame is admitted normally.
- 4-byte runt frame, then a 64-byte frame with tuser=1 on tlast, at 10M gap pattern (valid 1 in 100) -> dropped=1, bad=1, frames=1; output bytes spaced identically to input.
- Counters preset near all-ones via traffic with CNT_WIDTH=4 -> saturate at 15; stat_clear coincident with an increment -> counter reads 0.

Source files
------------

// File: rtl/eth_rx_frame_admit.sv
// eth_rx_frame_admit: destination-address admission, runt/oversize handling and per-frame
// statistics between the RX MAC stream and the RX FIFO write side.
module eth_rx_frame_admit #(
    parameter int MAX_FRAME_LENGTH = 1518,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                 rx_clk,
    input  logic                 rx_rst,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    input  logic                 cfg_enable,
    input  logic [47:0]          cfg_mac_addr,
    input  logic                 cfg_promisc,
    input  logic                 cfg_bcast_en,
    input  logic                 cfg_mcast_en,
    input  logic                 stat_clear,
    output logic [CNT_WIDTH-1:0] stat_rx_frames,
    output logic [CNT_WIDTH-1:0] stat_rx_bad,
    output logic [CNT_WIDTH-1:0] stat_rx_dropped,
    output logic [CNT_WIDTH-1:0] stat_rx_oversize
);
    typedef enum logic [1:0] {IDLE, HDR, PASS, DISCARD} state_t;
    localparam logic [15:0] LAST_BEAT = 16'(MAX_FRAME_LENGTH - 1);

    state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic en_q, en_d, match_q, match_d, bcast_q, bcast_d, mcast_q, mcast_d, rel_q, rel_d;
    logic [9:0] buf_q [8];
    logic [2:0] wr_ptr_q, rd_ptr_q;
    logic [3:0] count_q;
    logic [9:0] head;
    logic [7:0] mac_b, m_tdata_q;
    logic m_tvalid_q, m_tlast_q, m_tuser_q;
    logic [CNT_WIDTH-1:0] frames_q, bad_q, drop_q, over_q;
    logic wr, wr_last, wr_user, flush, pop, accept, byte_match, byte_ff;
    logic inc_frames, inc_bad, inc_drop, inc_over;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic inc, input logic clr);
        return clr ? '0 : (inc && !(&c)) ? c + CNT_WIDTH'(1) : c;
    endfunction

    // cnt_q indexes the header byte currently on the input while in HDR
    assign mac_b      = 8'(cfg_mac_addr >> (6'd40 - {cnt_q[2:0], 3'b000}));
    assign byte_match = s_axis_tdata == mac_b;
    assign byte_ff    = &s_axis_tdata;
    assign accept     = en_q & (cfg_promisc | (match_q & byte_match) | (cfg_bcast_en & bcast_q & byte_ff) |
                                (cfg_mcast_en & mcast_q & ~(bcast_q & byte_ff)));
    assign head       = buf_q[rd_ptr_q];
    assign pop        = rel_q & (count_q != 4'd0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        en_d       = en_q;
        match_d    = match_q;
        bcast_d    = bcast_q;
        mcast_d    = mcast_q;
        rel_d      = (pop & head[1]) ? 1'b0 : rel_q;
        wr         = 1'b0;
        wr_last    = 1'b0;
        wr_user    = 1'b0;
        flush      = 1'b0;
        inc_frames = 1'b0;
        inc_bad    = 1'b0;
        inc_drop   = 1'b0;
        inc_over   = 1'b0;
        if (s_axis_tvalid) begin
            case (state_q)
                IDLE: begin
                    if (count_q != 4'd0 || s_axis_tlast) begin
                        inc_drop = 1'b1;
                        state_d  = s_axis_tlast ? IDLE : DISCARD;
                    end else begin
                        en_d    = cfg_enable;
                        wr      = 1'b1;
                        cnt_d   = 16'd1;
                        match_d = s_axis_tdata == cfg_mac_addr[47:40];
                        bcast_d = byte_ff;
                        mcast_d = s_axis_tdata[0];
                        state_d = HDR;
                    end
                end
                HDR: begin
                    cnt_d   = cnt_q + 16'd1;
                    match_d = match_q & byte_match;
                    bcast_d = bcast_q & byte_ff;
                    if (s_axis_tlast || (cnt_q == 16'd5 && !accept)) begin
                        flush    = 1'b1;
                        inc_drop = 1'b1;
                        state_d  = s_axis_tlast ? IDLE : DISCARD;
                    end else begin
                        wr = 1'b1;
                        if (cnt_q == 16'd5) begin
                            rel_d   = 1'b1;
                            state_d = PASS;
                        end
                    end
                end
                PASS: begin
                    wr    = 1'b1;
                    cnt_d = cnt_q + 16'd1;
                    if (s_axis_tlast) begin
                        wr_last    = 1'b1;
                        wr_user    = s_axis_tuser;
                        inc_frames = 1'b1;
                        inc_bad    = s_axis_tuser;
                        state_d    = IDLE;
                    end else if (cnt_q == LAST_BEAT) begin
                        wr_last    = 1'b1;
                        wr_user    = 1'b1;
                        inc_frames = 1'b1;
                        inc_over   = 1'b1;
                        state_d    = DISCARD;
                    end
                end
                default: state_d = s_axis_tlast ? IDLE : DISCARD;
            endcase
        end
    end

    always_ff @(posedge rx_clk) begin
        if (wr) buf_q[wr_ptr_q] <= {s_axis_tdata, wr_last, wr_user};
    end

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            en_q       <= 1'b0;
            match_q    <= 1'b0;
            bcast_q    <= 1'b0;
            mcast_q    <= 1'b0;
            rel_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= 1'b0;
            frames_q   <= '0;
            bad_q      <= '0;
            drop_q     <= '0;
            over_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            match_q    <= match_d;
            bcast_q    <= bcast_d;
            mcast_q    <= mcast_d;
            rel_q      <= rel_d;
            wr_ptr_q   <= flush ? '0 : wr_ptr_q + {2'b0, wr};
            rd_ptr_q   <= flush ? '0 : rd_ptr_q + {2'b0, pop};
            count_q    <= flush ? '0 : count_q + {3'b0, wr} - {3'b0, pop};
            m_tvalid_q <= pop;
            if (pop) {m_tdata_q, m_tlast_q, m_tuser_q} <= head;
            frames_q   <= sat_inc(frames_q, inc_frames, stat_clear);
            bad_q      <= sat_inc(bad_q, inc_bad, stat_clear);
            drop_q     <= sat_inc(drop_q, inc_drop, stat_clear);
            over_q     <= sat_inc(over_q, inc_over, stat_clear);
        end
    end

    assign m_axis_tdata     = m_tdata_q;
    assign m_axis_tvalid    = m_tvalid_q;
    assign m_axis_tlast     = m_tlast_q;
    assign m_axis_tuser     = m_tuser_q;
    assign stat_rx_frames   = frames_q;
    assign stat_rx_bad      = bad_q;
    assign stat_rx_dropped  = drop_q;
    assign stat_rx_oversize = over_q;
endmodule
